// File: rtl/dimm_cmd_scheduler.sv
// In-order DDR5 command scheduler: a 16-entry request FIFO feeding a PRE/ACT/RD/WR
// sequencer with an open-page bank table and per-command spacing counters.
module dimm_cmd_scheduler #(
  parameter int QDEPTH = 16,
  parameter int T_RP   = 10,
  parameter int T_RCD  = 8,
  parameter int T_RTP  = 2,
  parameter int T_WR   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        done_pulse,
  output logic        err_pulse,
  output logic        busy,
  output logic [4:0]  q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = 8;
  localparam int EW = 34;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_REC
  } state_t;

  // ---------------- request queue ----------------
  logic [EW-1:0] q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    q_count_q;
  logic          push, pop;
  logic [EW-1:0] head;
  logic          unused_addr_bits;

  // Only the fields the sequencer uses are stored; bits [35:34] and [1:0] are dropped.
  assign unused_addr_bits = ^{req_addr[35:34], req_addr[1:0]};
  assign req_ready = (q_count_q < 5'(QDEPTH));
  assign push      = req_valid && req_ready;
  assign head      = q_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr_q] <= {req_op, req_addr[6], req_addr[9:7], req_addr[11:10],
                          req_addr[33:18], req_addr[17:12], req_addr[5:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   q_count_q <= q_count_q + 5'd1;
        2'b01:   q_count_q <= q_count_q - 5'd1;
        default: q_count_q <= q_count_q;
      endcase
    end
  end

  // ---------------- current request and bank table ----------------
  logic [1:0]  cur_op_q;
  logic        cur_ch_q;
  logic [2:0]  cur_bg_q;
  logic [1:0]  cur_ba_q;
  logic [15:0] cur_row_q;
  logic [9:0]  cur_col_q;

  logic        bank_open_q [32];
  logic [15:0] bank_row_q  [32];
  logic [4:0]  bank_idx;
  logic        bank_clr, bank_set;

  assign bank_idx = {cur_bg_q, cur_ba_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) bank_open_q[i] <= 1'b0;
    end else if (bank_clr) begin
      bank_open_q[bank_idx] <= 1'b0;
    end else if (bank_set) begin
      bank_open_q[bank_idx] <= 1'b1;
    end
  end

  // Row tags need no reset: they are only trusted while the open bit is set.
  always_ff @(posedge clk) begin
    if (bank_set) bank_row_q[bank_idx] <= cur_row_q;
  end

  // ---------------- sequencer ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cmd_valid_q;
  logic [2:0]    cmd_type_q, issue_type;
  logic [2:0]    cmd_bg_q;
  logic [1:0]    cmd_ba_q;
  logic [15:0]   cmd_row_q;
  logic [9:0]    cmd_col_q;
  logic          done_q, err_q, done_d, err_d;
  logic          issue, latch;
  logic          illegal, row_hit, cnt_zero;
  logic [2:0]    rw_type;
  logic [CW-1:0] rec_load;

  assign illegal  = (cur_op_q == 2'd3) || cur_ch_q;
  assign row_hit  = bank_open_q[bank_idx] && (bank_row_q[bank_idx] == cur_row_q);
  assign cnt_zero = (cnt_q == '0);
  assign rw_type  = (cur_op_q == 2'd1) ? CMD_WR : CMD_RD;
  assign rec_load = (cur_op_q == 2'd1) ? CW'(T_WR - 1) : CW'(T_RTP - 1);
  assign pop      = done_d || err_d;

  // Each command is registered on the edge that enters its state, so the state
  // name tracks the command on the bus and its spacing counter starts that cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_type = CMD_NOP;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch      = 1'b0;
    bank_clr   = 1'b0;
    bank_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (q_count_q != 5'd0 && !done_q && !err_q) begin
          latch   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (row_hit) begin
          issue = 1'b1; issue_type = rw_type; state_d = S_RW; cnt_d = rec_load;
        end else if (bank_open_q[bank_idx]) begin
          issue = 1'b1; issue_type = CMD_PRE; state_d = S_PRE; cnt_d = CW'(T_RP - 1);
          bank_clr = 1'b1;
        end else begin
          issue = 1'b1; issue_type = CMD_ACT; state_d = S_ACT; cnt_d = CW'(T_RCD - 1);
          bank_set = 1'b1;
        end
      end
      S_PRE, S_WAIT_RP: begin
        if (cnt_zero) begin
          issue = 1'b1; issue_type = CMD_ACT; state_d = S_ACT; cnt_d = CW'(T_RCD - 1);
          bank_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1; state_d = S_WAIT_RP;
        end
      end
      S_ACT, S_WAIT_RCD: begin
        if (cnt_zero) begin
          issue = 1'b1; issue_type = rw_type; state_d = S_RW; cnt_d = rec_load;
        end else begin
          cnt_d = cnt_q - 1'b1; state_d = S_WAIT_RCD;
        end
      end
      S_RW, S_WAIT_REC: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1; state_d = S_WAIT_REC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_NOP;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_op_q    <= '0;
      cur_ch_q    <= 1'b0;
      cur_bg_q    <= '0;
      cur_ba_q    <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= issue;
      cmd_type_q  <= issue_type;
      done_q      <= done_d;
      err_q       <= err_d;
      if (issue) begin
        cmd_bg_q  <= cur_bg_q;
        cmd_ba_q  <= cur_ba_q;
        cmd_row_q <= cur_row_q;
        cmd_col_q <= cur_col_q;
      end
      if (latch) begin
        {cur_op_q, cur_ch_q, cur_bg_q, cur_ba_q, cur_row_q, cur_col_q} <= head;
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_type   = cmd_type_q;
  assign cmd_bg     = cmd_bg_q;
  assign cmd_ba     = cmd_ba_q;
  assign cmd_row    = cmd_row_q;
  assign cmd_col    = cmd_col_q;
  assign done_pulse = done_q;
  assign err_pulse  = err_q;
  assign busy       = (state_q != S_IDLE);
  assign q_count    = q_count_q;

endmodule

// File: tb/tb_dimm_cmd_scheduler.sv
// Scoreboard bench for dimm_cmd_scheduler: a latency model pushes expected commands
// and retirements on each accepted request; a negedge monitor pops and compares them.
module tb_dimm_cmd_scheduler;
  localparam int T_RP = 10, T_RCD = 8, T_RTP = 2, T_WR = 6;

  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [35:0] req_addr = '0;
  logic        req_ready, cmd_valid, done_pulse, err_pulse, busy;
  logic [2:0]  cmd_type, cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [4:0]  q_count;

  dimm_cmd_scheduler #(.QDEPTH(16), .T_RP(T_RP), .T_RCD(T_RCD), .T_RTP(T_RTP), .T_WR(T_WR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .done_pulse(done_pulse), .err_pulse(err_pulse), .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          t;
    logic [2:0]  ty;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
  } exp_cmd_t;
  typedef struct {
    int t;
    bit is_err;
  } exp_ev_t;

  exp_cmd_t    cmd_q[$];
  exp_ev_t     ev_q[$];
  bit          m_open[32];
  logic [15:0] m_row[32];
  int          prev_end = -100;
  int          done_log[$];
  int          qmax = 0;

  function automatic logic [35:0] mk_addr(input logic [15:0] row, input logic [2:0] bg,
                                          input logic [1:0] ba, input logic [9:0] col,
                                          input logic ch);
    logic [35:0] a;
    a = '0;
    a[33:18] = row;
    a[17:12] = col[9:4];
    a[5:2]   = col[3:0];
    a[11:10] = ba;
    a[9:7]   = bg;
    a[6]     = ch;
    return a;
  endfunction

  task automatic push_cmd(input int t, input logic [2:0] ty, input logic [35:0] a);
    exp_cmd_t e;
    e.t = t; e.ty = ty; e.bg = a[9:7]; e.ba = a[11:10];
    e.row = a[33:18]; e.col = {a[17:12], a[5:2]};
    cmd_q.push_back(e);
  endtask

  // Latency model: DECODE one cycle after accept, or two cycles after the previous retirement.
  task automatic model_accept(input int k, input logic [1:0] op, input logic [35:0] a);
    int d, t;
    logic [4:0]  idx;
    logic [15:0] row;
    exp_ev_t     ev;
    d   = (k + 1 > prev_end + 2) ? k + 1 : prev_end + 2;
    t   = d + 1;
    row = a[33:18];
    idx = {a[9:7], a[11:10]};
    if (op == 2'd3 || a[6]) begin
      ev.t = t; ev.is_err = 1'b1;
      ev_q.push_back(ev);
      prev_end = t;
      return;
    end
    if (!(m_open[idx] && m_row[idx] == row)) begin
      if (m_open[idx]) begin
        push_cmd(t, 3'd4, a);
        t += T_RP;
      end
      push_cmd(t, 3'd1, a);
      m_open[idx] = 1'b1;
      m_row[idx]  = row;
      t += T_RCD;
    end
    push_cmd(t, (op == 2'd1) ? 3'd3 : 3'd2, a);
    t += (op == 2'd1) ? T_WR : T_RTP;
    ev.t = t; ev.is_err = 1'b0;
    ev_q.push_back(ev);
    prev_end = t;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_open[i] = 1'b0;
    prev_end = -100;
    cmd_q.delete();
    ev_q.delete();
  endtask

  // Called just after a negedge; leaves req_valid high so calls chain back-to-back.
  task automatic send(input logic [1:0] op, input logic [35:0] a, output int k);
    bit rdy;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    for (int i = 0; i < 300; i++) begin
      rdy = req_ready;
      @(negedge clk);
      if (rdy) begin
        k = cyc;
        model_accept(k, op, a);
        return;
      end
    end
    check("accept_timeout", 1, 0);
    k = -1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_q.size() == 0 && ev_q.size() == 0 && q_count == 0 && !busy) break;
    end
    check("drain_pending", cmd_q.size() + ev_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (q_count > qmax) qmax = q_count;
      check("req_ready_rule", req_ready, (q_count < 5'd16));
      check("done_err_excl", done_pulse & err_pulse, 0);
      if (cmd_valid) begin
        $display("[TB] cyc %0d cmd type %0d bg %0d ba %0d row 0x%0h col 0x%0h",
                 cyc, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col);
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 1, 0);
        end else begin
          exp_cmd_t e;
          e = cmd_q.pop_front();
          check("cmd_cycle", cyc, e.t);
          check("cmd_type", cmd_type, e.ty);
          check("cmd_bg", cmd_bg, e.bg);
          check("cmd_ba", cmd_ba, e.ba);
          if (e.ty == 3'd1) check("cmd_row", cmd_row, e.row);
          if (e.ty == 3'd2 || e.ty == 3'd3) check("cmd_col", cmd_col, e.col);
        end
      end else begin
        check("nop_type", cmd_type, 0);
      end
      if (done_pulse || err_pulse) begin
        $display("[TB] cyc %0d retire %s", cyc, err_pulse ? "err" : "done");
        if (done_pulse) done_log.push_back(cyc);
        if (ev_q.size() == 0) begin
          check("retire_unexpected", 1, 0);
        end else begin
          exp_ev_t ev;
          ev = ev_q.pop_front();
          check("retire_cycle", cyc, ev.t);
          check("retire_is_err", err_pulse, ev.is_err);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_type"}, cmd_type, 0);
    check({tag, "_cmd_fields"}, {cmd_bg, cmd_ba, cmd_row, cmd_col}, 0);
    check({tag, "_done"}, done_pulse, 0);
    check({tag, "_err"}, err_pulse, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_q_count"}, q_count, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  int k0, k1, kx;
  int acc[20];

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Closed-bank read followed by a queued row-hit write.
    done_log.delete();
    send(2'd0, mk_addr(16'h0001, 3'd0, 2'd0, 10'h000, 1'b0), k0);
    send(2'd1, mk_addr(16'h0001, 3'd0, 2'd0, 10'h015, 1'b0), k1);
    idle();
    wait_drain();
    check("closed_read_done_lat", done_log.size() > 0 ? done_log[0] - k0 : -1, 12);
    check("hit_write_done_lat", done_log.size() > 1 ? done_log[1] - k0 : -1, 21);

    // Row conflict on the same bank.
    done_log.delete();
    send(2'd0, mk_addr(16'h0002, 3'd0, 2'd0, 10'h003, 1'b0), k0);
    idle();
    wait_drain();
    check("conflict_done_lat", done_log.size() > 0 ? done_log[0] - k0 : -1, 22);

    // Illegal op, illegal channel, then a fetch that must still hit row 2.
    send(2'd3, mk_addr(16'h0002, 3'd0, 2'd0, 10'h000, 1'b0), kx);
    send(2'd0, mk_addr(16'h0005, 3'd0, 2'd0, 10'h000, 1'b1), kx);
    send(2'd2, mk_addr(16'h0002, 3'd0, 2'd0, 10'h007, 1'b0), kx);
    idle();
    wait_drain();

    // 20 back-to-back requests: a conflict first, then hits, to fill the queue.
    done_log.delete();
    qmax = 0;
    for (int i = 0; i < 20; i++) begin
      send(2'(i % 3), mk_addr(16'h0003, 3'd0, 2'd0, 10'(i * 5), 1'b0), acc[i]);
    end
    idle();
    wait_drain();
    check("qfull_peak", qmax, 16);
    check("qfull_retired", done_log.size(), 20);
    check("qfull_17th_accept", done_log.size() > 0 ? acc[16] - done_log[0] : -1, 1);

    // Reset while waiting tRCD, then the same row must be reopened with an ACT.
    send(2'd0, mk_addr(16'h0007, 3'd2, 2'd1, 10'h001, 1'b0), k0);
    idle();
    for (int i = 0; i < 50 && cyc < k0 + 5; i++) @(negedge clk);
    check("mid_busy", busy, 1);
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    done_log.delete();
    send(2'd0, mk_addr(16'h0007, 3'd2, 2'd1, 10'h001, 1'b0), k0);
    idle();
    wait_drain();
    check("post_reset_done_lat", done_log.size() > 0 ? done_log[0] - k0 : -1, 12);

    check("leftover_expect", cmd_q.size() + ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
